// File: rtl/mio_bus_n.sv
// Memory-mapped I/O bus controller: decodes the CPU address into one of N_SLV
// windows and runs a registered request / wait-state / acknowledge handshake.
module mio_bus_n #(
  parameter int                 N_SLV    = 4,
  parameter int                 DW       = 32,
  parameter logic [N_SLV*4-1:0] SLV_BASE = {4'hF, 4'hE, 4'hC, 4'h0},
  parameter logic [N_SLV*4-1:0] WAIT_CYC = {4'd0, 4'd0, 4'd2, 4'd1}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                mem_w,
  input  logic [31:0]         addr_bus,
  input  logic [DW-1:0]       cpu_data2bus,
  output logic [DW-1:0]       cpu_data4bus,
  output logic                CPU_wait,
  output logic                ack,
  output logic [N_SLV-1:0]    slv_sel,
  output logic [N_SLV-1:0]    slv_we,
  output logic [27:0]         slv_addr,
  output logic [DW-1:0]       slv_wdata,
  input  logic [N_SLV*DW-1:0] slv_rdata,
  output logic                err,
  input  logic                err_clr,
  output logic [31:0]         err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_wr, w_wr_nxt;
  logic [DW-1:0]    r_rdata, w_rdata_nxt;
  logic             r_wait, w_wait_nxt;
  logic             r_ack, w_ack_nxt;
  logic [N_SLV-1:0] r_sel, w_sel_nxt;
  logic [N_SLV-1:0] r_we, w_we_nxt;
  logic [27:0]      r_addr, w_addr_nxt;
  logic [DW-1:0]    r_wdata, w_wdata_nxt;
  logic             r_err, w_err_nxt;
  logic [31:0]      r_eaddr, w_eaddr_nxt;

  logic             w_hit;
  logic [N_SLV-1:0] w_hit_oh;
  logic [3:0]       w_hit_wait;
  logic [DW-1:0]    w_slv_rd;

  // Scan from the top index down so the lowest matching window wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_oh   = '0;
    w_hit_wait = 4'd0;
    for (int k = N_SLV - 1; k >= 0; k--) begin
      if (addr_bus[31:28] == SLV_BASE[4*k +: 4]) begin
        w_hit       = 1'b1;
        w_hit_oh    = '0;
        w_hit_oh[k] = 1'b1;
        w_hit_wait  = WAIT_CYC[4*k +: 4];
      end
    end
  end

  always_comb begin
    w_slv_rd = '0;
    for (int k = 0; k < N_SLV; k++) begin
      if (r_sel[k]) w_slv_rd = w_slv_rd | slv_rdata[DW*k +: DW];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_nxt    = r_wr;
    w_rdata_nxt = r_rdata;
    w_wait_nxt  = 1'b0;
    w_ack_nxt   = 1'b0;
    w_sel_nxt   = r_sel;
    w_we_nxt    = '0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_err_nxt   = r_err & ~err_clr;
    w_eaddr_nxt = r_eaddr;
    case (r_state)
      S_IDLE: begin
        w_sel_nxt = '0;
        if (req) begin
          w_wr_nxt    = mem_w;
          w_addr_nxt  = addr_bus[27:0];
          w_wdata_nxt = cpu_data2bus;
          // CPU_wait rises on both paths so a miss still shows one wait cycle.
          w_wait_nxt  = 1'b1;
          if (w_hit) begin
            w_state_nxt = S_ACCESS;
            w_sel_nxt   = w_hit_oh;
            w_we_nxt    = mem_w ? w_hit_oh : '0;
            w_cnt_nxt   = w_hit_wait;
          end else begin
            w_state_nxt = S_DONE;
            w_ack_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
            if (!mem_w) w_rdata_nxt = '0;
            if (!r_err || err_clr) w_eaddr_nxt = addr_bus;
          end
        end
      end
      S_ACCESS: begin
        w_wait_nxt = 1'b1;
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          if (!r_wr) w_rdata_nxt = w_slv_rd;
          w_state_nxt = S_DONE;
          w_ack_nxt   = 1'b1;
          w_wait_nxt  = 1'b0;
          w_sel_nxt   = '0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sel_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
      r_wait  <= 1'b0;
      r_ack   <= 1'b0;
      r_sel   <= '0;
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      r_eaddr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wr    <= w_wr_nxt;
      r_rdata <= w_rdata_nxt;
      r_wait  <= w_wait_nxt;
      r_ack   <= w_ack_nxt;
      r_sel   <= w_sel_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_err   <= w_err_nxt;
      r_eaddr <= w_eaddr_nxt;
    end
  end

  assign cpu_data4bus = r_rdata;
  assign CPU_wait     = r_wait;
  assign ack          = r_ack;
  assign slv_sel      = r_sel;
  assign slv_we       = r_we;
  assign slv_addr     = r_addr;
  assign slv_wdata    = r_wdata;
  assign err          = r_err;
  assign err_addr     = r_eaddr;

endmodule

// File: tb/tb_mio_bus_n.sv
// Directed bench for mio_bus_n with the default four-slave map
// (bases 0/C/E/F, wait states 1/2/0/0).
module tb_mio_bus_n;

  logic         clk = 1'b0;
  logic         rst, req, mem_w, err_clr;
  logic [31:0]  addr_bus, cpu_data2bus;
  logic [31:0]  cpu_data4bus, err_addr;
  logic         CPU_wait, ack, err;
  logic [3:0]   slv_sel, slv_we;
  logic [27:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [127:0] slv_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mio_bus_n dut (
    .clk(clk), .rst(rst), .req(req), .mem_w(mem_w), .addr_bus(addr_bus),
    .cpu_data2bus(cpu_data2bus), .cpu_data4bus(cpu_data4bus),
    .CPU_wait(CPU_wait), .ack(ack), .slv_sel(slv_sel), .slv_we(slv_we),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata),
    .err(err), .err_clr(err_clr), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 1'b1; mem_w = 1'b0; err_clr = 1'b0;
    addr_bus = 32'h0; cpu_data2bus = 32'h0;
    slv_rdata = {32'hCAFE_F00D, 32'h5555_AAAA, 32'hDEAD_BEEF, 32'h1234_5678};

    // Reset held two cycles with req high
    tick(); tick();
    chk("rst_rdata", cpu_data4bus, 0);
    chk("rst_wait",  CPU_wait, 0);
    chk("rst_ack",   ack, 0);
    chk("rst_sel",   slv_sel, 0);
    chk("rst_we",    slv_we, 0);
    chk("rst_addr",  slv_addr, 0);
    chk("rst_wdata", slv_wdata, 0);
    chk("rst_err",   err, 0);
    chk("rst_eaddr", err_addr, 0);
    rst = 1'b0; req = 1'b0;
    tick();
    chk("idle_sel", slv_sel, 0);

    // Read slave 0, one wait state: ack at T+3
    addr_bus = 32'h0000_0040; mem_w = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    chk("rd0_t1_sel",  slv_sel, 4'b0001);
    chk("rd0_t1_wait", CPU_wait, 1);
    chk("rd0_t1_ack",  ack, 0);
    chk("rd0_t1_we",   slv_we, 0);
    chk("rd0_t1_addr", slv_addr, 28'h000_0040);
    tick();
    chk("rd0_t2_sel",  slv_sel, 4'b0001);
    chk("rd0_t2_ack",  ack, 0);
    tick();
    chk("rd0_t3_ack",  ack, 1);
    chk("rd0_t3_sel",  slv_sel, 0);
    chk("rd0_t3_wait", CPU_wait, 0);
    chk("rd0_t3_data", cpu_data4bus, 32'h1234_5678);
    tick();
    chk("rd0_t4_ack",  ack, 0);

    // Write slave 1, two wait states: one-cycle strobe, ack at T+4
    addr_bus = 32'hC000_0004; cpu_data2bus = 32'hA5A5_A5A5; mem_w = 1'b1; req = 1'b1;
    tick();
    req = 1'b0; cpu_data2bus = 32'h0;
    chk("wr1_t1_we",    slv_we, 4'b0010);
    chk("wr1_t1_sel",   slv_sel, 4'b0010);
    chk("wr1_t1_wdata", slv_wdata, 32'hA5A5_A5A5);
    chk("wr1_t1_addr",  slv_addr, 28'h000_0004);
    tick();
    chk("wr1_t2_we",    slv_we, 0);
    chk("wr1_t2_sel",   slv_sel, 4'b0010);
    tick();
    chk("wr1_t3_ack",   ack, 0);
    chk("wr1_t3_wait",  CPU_wait, 1);
    tick();
    chk("wr1_t4_ack",   ack, 1);
    chk("wr1_t4_data",  cpu_data4bus, 32'h1234_5678);
    chk("wr1_t4_wdata", slv_wdata, 32'hA5A5_A5A5);
    tick();

    // Unmapped read: ack at T+1 with CPU_wait still high
    addr_bus = 32'h8000_0000; mem_w = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    chk("miss1_ack",   ack, 1);
    chk("miss1_wait",  CPU_wait, 1);
    chk("miss1_sel",   slv_sel, 0);
    chk("miss1_data",  cpu_data4bus, 0);
    chk("miss1_err",   err, 1);
    chk("miss1_eaddr", err_addr, 32'h8000_0000);
    tick();
    chk("miss1_t2_ack",  ack, 0);
    chk("miss1_t2_wait", CPU_wait, 0);
    addr_bus = 32'h9000_0000; req = 1'b1;
    tick();
    req = 1'b0;
    chk("miss2_ack",   ack, 1);
    chk("miss2_eaddr", err_addr, 32'h8000_0000);
    chk("miss2_err",   err, 1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_err",   err, 0);
    chk("clr_eaddr", err_addr, 32'h8000_0000);

    // Back-to-back reads of slave 3 with req held high
    addr_bus = 32'hF000_0010; mem_w = 1'b0; req = 1'b1;
    tick();
    chk("b2b_t1_sel", slv_sel, 4'b1000);
    chk("b2b_t1_ack", ack, 0);
    tick();
    chk("b2b_t2_ack",  ack, 1);
    chk("b2b_t2_sel",  slv_sel, 0);
    chk("b2b_t2_data", cpu_data4bus, 32'hCAFE_F00D);
    slv_rdata[127:96] = 32'h0BAD_CAFE;
    tick();
    chk("b2b_t3_ack", ack, 0);
    chk("b2b_t3_sel", slv_sel, 0);
    tick();
    chk("b2b_t4_sel", slv_sel, 4'b1000);
    chk("b2b_t4_ack", ack, 0);
    tick();
    req = 1'b0;
    chk("b2b_t5_ack",  ack, 1);
    chk("b2b_t5_data", cpu_data4bus, 32'h0BAD_CAFE);
    tick();

    // Write miss keeps read data; err was clear so err_addr loads
    addr_bus = 32'hD000_0000; mem_w = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    chk("wmiss_ack",   ack, 1);
    chk("wmiss_data",  cpu_data4bus, 32'h0BAD_CAFE);
    chk("wmiss_err",   err, 1);
    chk("wmiss_eaddr", err_addr, 32'hD000_0000);
    chk("wmiss_we",    slv_we, 0);
    tick();

    // Clear and new miss together: set wins, err_addr reloads
    addr_bus = 32'h9000_0000; mem_w = 1'b0; req = 1'b1; err_clr = 1'b1;
    tick();
    req = 1'b0; err_clr = 1'b0;
    chk("setclr_err",   err, 1);
    chk("setclr_eaddr", err_addr, 32'h9000_0000);
    chk("setclr_data",  cpu_data4bus, 0);
    tick();

    // Reset mid-ACCESS on slave 1: no ack afterwards
    addr_bus = 32'hC000_0000; mem_w = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    chk("rsta_sel", slv_sel, 4'b0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsta_sel0",  slv_sel, 0);
    chk("rsta_wait0", CPU_wait, 0);
    chk("rsta_ack0",  ack, 0);
    chk("rsta_err0",  err, 0);
    chk("rsta_eadr0", err_addr, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rsta_noack", ack, 0);
      chk("rsta_nosel", slv_sel, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
